// File: rtl/frame_check_gen.sv
// frame_check_gen: hunts the two-byte header, tracks byte position and length, checks PID/type/checksum,
// times out truncated frames and flags enquiries repeated inside the enquiry window.
module frame_check_gen #(
  parameter logic [7:0] HEAD0   = 8'hEB,
  parameter logic [7:0] HEAD1   = 8'h90,
  parameter logic [7:0] PID_A   = 8'h04,
  parameter logic [7:0] PID_B   = 8'h00,
  parameter int         LEN_W   = 9,
  parameter int         TO_CYC  = 12000,
  parameter int         ENQ_WIN = 12000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [7:0]       rx_data,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             HCE,
  output logic             PIE,
  output logic             ITE,
  output logic             CSE,
  output logic             LCE,
  output logic             ECE,
  output logic [7:0]       ins_type,
  output logic [LEN_W-1:0] addr
);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int EW = $clog2(ENQ_WIN + 1);

  typedef enum logic [2:0] {HUNT, H1, PID, TYPE, BODY, CK1, CK0} state_t;

  function automatic logic [LEN_W-1:0] len_of(input logic [7:0] t);
    case (t)
      8'h63:        len_of = LEN_W'(53);
      8'h87:        len_of = LEN_W'(25);
      8'h94, 8'h25: len_of = LEN_W'(9);
      8'h13:        len_of = LEN_W'(13);
      8'hFF, 8'hF0: len_of = LEN_W'(4);
      8'h76:        len_of = LEN_W'(268);
      default:      len_of = '0;
    endcase
  endfunction

  function automatic logic is_enq(input logic [7:0] t);
    is_enq = t == 8'h63 || t == 8'h13 || t == 8'h25;
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] addr_q, addr_d, len_q, len_d, tlen;
  logic [15:0]      sum_q, sum_d;
  logic [7:0]       ck_hi_q, ck_hi_d, typ_q, typ_d, ins_type_q, ins_type_d;
  logic             pid_bad_q, pid_bad_d, enq_hit_q, enq_hit_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [EW-1:0]    enq_cnt_q, enq_cnt_d;
  logic             done_q, done_d, ok_q, ok_d;
  logic             hce_q, hce_d, pie_q, pie_d, ite_q, ite_d, cse_q, cse_d, lce_q, lce_d, ece_q, ece_d;
  logic             fin, f_hce, f_ite, f_cse, f_lce, other_err;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    sum_d      = sum_q;
    ck_hi_d    = ck_hi_q;
    typ_d      = typ_q;
    pid_bad_d  = pid_bad_q;
    enq_hit_d  = enq_hit_q;
    to_cnt_d   = (state_q == HUNT || valid) ? '0 : to_cnt_q + 1'b1;
    enq_cnt_d  = enq_cnt_q != '0 ? enq_cnt_q - 1'b1 : '0;
    done_d     = 1'b0;
    ok_d       = ok_q;
    hce_d      = hce_q;
    pie_d      = pie_q;
    ite_d      = ite_q;
    cse_d      = cse_q;
    lce_d      = lce_q;
    ece_d      = ece_q;
    ins_type_d = ins_type_q;
    fin        = 1'b0;
    f_hce      = 1'b0;
    f_ite      = 1'b0;
    f_cse      = 1'b0;
    f_lce      = 1'b0;
    tlen       = len_of(rx_data);
    if (!valid) begin
      if (state_q != HUNT && to_cnt_q == TW'(TO_CYC - 1)) begin
        fin   = 1'b1;
        f_lce = 1'b1;
      end
    end else begin
      case (state_q)
        HUNT: if (rx_data == HEAD0) begin
          state_d   = H1;
          addr_d    = LEN_W'(1);
          pid_bad_d = 1'b0;
          enq_hit_d = 1'b0;
          typ_d     = '0;
        end
        H1: if (rx_data == HEAD1) begin
          state_d = PID;
          addr_d  = LEN_W'(2);
        end else if (rx_data != HEAD0) begin
          fin   = 1'b1;
          f_hce = 1'b1;
        end
        PID: begin
          sum_d     = {8'h00, rx_data};
          pid_bad_d = rx_data != PID_A && rx_data != PID_B;
          state_d   = TYPE;
          addr_d    = LEN_W'(3);
        end
        TYPE: begin
          typ_d     = rx_data;
          enq_hit_d = is_enq(rx_data) && enq_cnt_q != '0;
          if (tlen == '0) begin
            fin   = 1'b1;
            f_ite = 1'b1;
          end else if (tlen == LEN_W'(4)) begin
            fin = 1'b1;
          end else begin
            sum_d   = sum_q + {8'h00, rx_data};
            len_d   = tlen;
            addr_d  = LEN_W'(4);
            state_d = BODY;
          end
        end
        BODY: begin
          sum_d   = sum_q + {8'h00, rx_data};
          addr_d  = addr_q + 1'b1;
          state_d = addr_q == len_q - LEN_W'(3) ? CK1 : BODY;
        end
        CK1: begin
          ck_hi_d = rx_data;
          addr_d  = addr_q + 1'b1;
          state_d = CK0;
        end
        CK0: begin
          fin   = 1'b1;
          f_cse = {ck_hi_q, rx_data} != sum_q;
        end
        default: state_d = HUNT;
      endcase
    end
    other_err = f_hce | pid_bad_d | f_ite | f_cse | f_lce;
    if (fin) begin
      state_d    = HUNT;
      addr_d     = '0;
      done_d     = 1'b1;
      hce_d      = f_hce;
      pie_d      = pid_bad_d;
      ite_d      = f_ite;
      cse_d      = f_cse;
      lce_d      = f_lce;
      ece_d      = enq_hit_d;
      ok_d       = !(other_err | enq_hit_d);
      ins_type_d = typ_d;
      // a clean enquiry (ECE alone does not disqualify it) restarts the repeat window
      if (is_enq(typ_d) && !other_err) enq_cnt_d = EW'(ENQ_WIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      addr_q     <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      ck_hi_q    <= '0;
      typ_q      <= '0;
      pid_bad_q  <= 1'b0;
      enq_hit_q  <= 1'b0;
      to_cnt_q   <= '0;
      enq_cnt_q  <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      hce_q      <= 1'b0;
      pie_q      <= 1'b0;
      ite_q      <= 1'b0;
      cse_q      <= 1'b0;
      lce_q      <= 1'b0;
      ece_q      <= 1'b0;
      ins_type_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      ck_hi_q    <= ck_hi_d;
      typ_q      <= typ_d;
      pid_bad_q  <= pid_bad_d;
      enq_hit_q  <= enq_hit_d;
      to_cnt_q   <= to_cnt_d;
      enq_cnt_q  <= enq_cnt_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      hce_q      <= hce_d;
      pie_q      <= pie_d;
      ite_q      <= ite_d;
      cse_q      <= cse_d;
      lce_q      <= lce_d;
      ece_q      <= ece_d;
      ins_type_q <= ins_type_d;
    end
  end

  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign HCE        = hce_q;
  assign PIE        = pie_q;
  assign ITE        = ite_q;
  assign CSE        = cse_q;
  assign LCE        = lce_q;
  assign ECE        = ece_q;
  assign ins_type   = ins_type_q;
  assign addr       = addr_q;
endmodule

// File: tb/tb_frame_check_gen.sv
// tb_frame_check_gen: frame-level reference model feeding a scoreboard, with a decoupled monitor.
module tb_frame_check_gen;
  localparam int TO = 40;
  localparam int EW = 300;

  logic       clk = 0, rst_n = 0, valid = 0;
  logic [7:0] rx_data = 0;
  logic       frame_done, frame_ok, HCE, PIE, ITE, CSE, LCE, ECE;
  logic [7:0] ins_type;
  logic [8:0] addr;

  frame_check_gen #(.TO_CYC(TO), .ENQ_WIN(EW)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .rx_data(rx_data),
    .frame_done(frame_done), .frame_ok(frame_ok), .HCE(HCE), .PIE(PIE), .ITE(ITE),
    .CSE(CSE), .LCE(LCE), .ECE(ECE), .ins_type(ins_type), .addr(addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_n;
    logic [5:0] fl;
    logic       chk_t;
    logic [7:0] t;
  } exp_t;

  exp_t       sq[$];
  exp_t       me;
  int         total = 0, bad = 0;
  int         last_e = 0, enq_s = 0;
  bit         enq_live = 0;
  logic [6:0] held = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic int len_of(input logic [7:0] t);
    case (t)
      8'h63: return 53;
      8'h87: return 25;
      8'h94: return 9;
      8'h13: return 13;
      8'h25: return 9;
      8'hFF: return 4;
      8'hF0: return 4;
      8'h76: return 268;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_enq(input logic [7:0] t);
    return t == 8'h63 || t == 8'h13 || t == 8'h25;
  endfunction

  task automatic put(input logic [7:0] b, input int gap);
    repeat (gap) begin @(negedge clk); valid = 0; end
    @(negedge clk);
    valid   = 1;
    rx_data = b;
    last_e  = cyc + 1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin @(negedge clk); valid = 0; end
  endtask

  // corrupt: 0 none, 1 LSB, 2 MSB; cut: bytes sent before silence (0 = whole frame)
  task automatic frame(input logic [7:0] pid, input logic [7:0] t, input int corrupt,
                       input int cut, input bit dbl, input int gmax);
    logic [7:0]  b[$];
    logic [15:0] s;
    int          n, nb, te;
    bit          pbad, ece, cse, typ_seen;
    exp_t        e;
    n = len_of(t);
    b = '{8'hEB, 8'h90, pid, t};
    if (n > 4) begin
      for (int i = 4; i < n - 2; i++) b.push_back(8'($urandom));
      s = 0;
      for (int i = 2; i < n - 2; i++) s += 16'(b[i]);
      if (corrupt == 1) s[7:0] = s[7:0] ^ 8'($urandom_range(1, 255));
      if (corrupt == 2) s[15:8] = s[15:8] ^ 8'($urandom_range(1, 255));
      b.push_back(s[15:8]);
      b.push_back(s[7:0]);
    end
    if (cut >= b.size()) cut = 0;
    nb = cut != 0 ? cut : b.size();
    if (dbl) put(8'hEB, $urandom_range(0, gmax));
    te = 0;
    for (int i = 0; i < nb; i++) begin
      put(b[i], $urandom_range(0, gmax));
      if (i == 3) te = last_e;
    end
    typ_seen = nb >= 4;
    pbad     = nb >= 3 && pid != 8'h04 && pid != 8'h00;
    ece      = typ_seen && is_enq(t) && enq_live && (te - enq_s <= EW);
    cse      = cut == 0 && n > 4 && corrupt != 0;
    e.fl     = {1'b0, pbad, typ_seen && n == 0, cse, cut != 0, ece};
    e.chk_t  = typ_seen;
    e.t      = t;
    e.edge_n = cut != 0 ? last_e + TO : last_e;
    sq.push_back(e);
    if (cut == 0 && is_enq(t) && !pbad && !cse) begin
      enq_live = 1;
      enq_s    = last_e;
    end
    if (cut != 0) quiet(TO + 5);
  endtask

  task automatic hce_frame();
    logic [7:0] x;
    exp_t e;
    do x = 8'($urandom); while (x == 8'hEB || x == 8'h90);
    put(8'hEB, $urandom_range(0, 2));
    put(x, $urandom_range(0, 2));
    e.fl = 6'b100000; e.chk_t = 0; e.t = 0; e.edge_n = last_e;
    sq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) held = '0;
    else if (frame_done) begin
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got pulse want none (edge %0d)", cyc);
        held = {HCE, PIE, ITE, CSE, LCE, ECE, frame_ok};
      end else begin
        me = sq.pop_front();
        chk("done_edge", cyc, me.edge_n);
        chk("flags", {HCE, PIE, ITE, CSE, LCE, ECE}, me.fl);
        chk("frame_ok", frame_ok, me.fl == 0);
        chk("addr_end", addr, 0);
        if (me.chk_t) chk("ins_type", ins_type, me.t);
        held = {me.fl, me.fl == 0};
      end
    end else chk("hold", {HCE, PIE, ITE, CSE, LCE, ECE, frame_ok}, held);
  end

  logic [7:0] tt, pp;
  logic [7:0] tbl [8] = '{8'h63, 8'h87, 8'h94, 8'h13, 8'h25, 8'hFF, 8'hF0, 8'h76};

  initial begin
    quiet(3);
    chk("reset_outputs", {frame_done, frame_ok, HCE, PIE, ITE, CSE, LCE, ECE, ins_type, addr}, 0);
    rst_n = 1;
    quiet(2);
    frame(8'h04, 8'h94, 0, 0, 0, 1);
    frame(8'h04, 8'h94, 1, 0, 0, 1);
    frame(8'h04, 8'h94, 2, 0, 0, 1);
    hce_frame();
    frame(8'h04, 8'hFF, 0, 0, 1, 1);
    frame(8'h04, 8'h55, 0, 0, 0, 1);
    frame(8'h07, 8'h25, 0, 0, 0, 1);
    frame(8'h04, 8'h87, 0, 4, 0, 0);
    quiet(EW + 10);
    frame(8'h04, 8'h13, 0, 0, 0, 1);
    quiet(100);
    frame(8'h04, 8'h13, 0, 0, 0, 1);
    quiet(EW + 50);
    frame(8'h00, 8'h13, 0, 0, 0, 1);
    quiet(5);
    put(8'hEB, 0); put(8'h90, 0); put(8'h04, 0);
    quiet(1);
    chk("addr_mid", addr, 3);
    rst_n = 0;
    quiet(2);
    chk("midreset_outputs", {frame_done, frame_ok, HCE, PIE, ITE, CSE, LCE, ECE, ins_type, addr}, 0);
    enq_live = 0;
    rst_n = 1;
    quiet(2);
    for (int k = 0; k < 120; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) hce_frame();
      else if (r == 1) begin
        repeat ($urandom_range(1, 3)) begin
          do tt = 8'($urandom); while (tt == 8'hEB);
          put(tt, $urandom_range(0, 2));
        end
      end else begin
        r = $urandom_range(0, 8);
        if (r == 8) begin
          do tt = 8'($urandom); while (len_of(tt) != 0);
        end else tt = tbl[r];
        if (tt == 8'h76 && $urandom_range(0, 7) != 0) tt = 8'h13;
        pp = $urandom_range(0, 4) != 0 ? ($urandom_range(0, 1) ? 8'h04 : 8'h00) : 8'($urandom);
        frame(pp, tt, $urandom_range(0, 4) == 0 ? $urandom_range(1, 2) : 0,
              $urandom_range(0, 6) == 0 ? $urandom_range(1, 6) : 0,
              $urandom_range(0, 9) == 0, 3);
      end
      r = $urandom_range(0, 9);
      if (r < 7) quiet($urandom_range(0, 3));
      else if (r < 9) quiet($urandom_range(100, 250));
      else quiet($urandom_range(320, 400));
    end
    quiet(TO + 20);
    chk("pending_frames", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
